// File: rtl/sb_config_loader.sv
// sb_config_loader
//   Serial configuration loader for a column of fullSB switch boxes. A frame
//   is shifted MSB-first into a shadow register through a valid/ready
//   handshake. Each word is then validated, and the whole frame is committed
//   atomically to config_out. The switch boxes therefore never observe a
//   partial or illegal routing.
//
//   Word layout (CFG_W=9): {mode, n_dve,n_dvn, e_dve,e_dvn, s_dve,s_dvn, w_dve,w_dvn}
//   A word is legal when at most two of its dve bits are set.
//
//   Build option: define SB_CFG_PARITY_EN to append one even-parity bit to
//   each frame. The frame length becomes NUM_SB*CFG_W+1, and a parity
//   mismatch rejects the frame.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   cfg_start   begin a frame (from IDLE) or restart it (during SHIFT)
//   cfg_valid   cfg_bit carries a frame bit this cycle
//   cfg_bit     serial frame bit, MSB first
//   cfg_ready   loader accepts a bit this cycle
//   busy        loader is not idle
//   cfg_done    one-cycle pulse after a frame is committed
//   cfg_error   sticky; set when the last frame was rejected
//   config_out  active configuration; SB i uses config_out[i*CFG_W +: CFG_W]
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for cfg_start; config_out holds the last good frame
// SHIFT | accepting frame bits into the shadow register
// CHECK | one cycle: validate the shadow, then commit or flag an error

module sb_config_loader #(
   parameter int NUM_SB = 4,
   parameter int CFG_W  = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_start,
   input  logic                      cfg_valid,
   input  logic                      cfg_bit,
   output logic                      cfg_ready,
   output logic                      busy,
   output logic                      cfg_done,
   output logic                      cfg_error,
   output logic [NUM_SB*CFG_W-1:0]   config_out
);

   localparam int N = NUM_SB * CFG_W;
`ifdef SB_CFG_PARITY_EN
   localparam int FRAME = N + 1;
`else
   localparam int FRAME = N;
`endif
   localparam int CNT_W = $clog2(FRAME + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [N-1:0]      shadow;
   logic [CNT_W-1:0]  bit_cnt;
   logic              accept;
   logic              frame_ok;
`ifdef SB_CFG_PARITY_EN
   logic              par_bit;
`endif

   // dve bits occupy the odd positions below the mode bit (1,3,5,7).
   function automatic logic all_words_legal(input logic [N-1:0] s);
      logic ok;
      int   n_dve;
      ok = 1'b1;
      for (int i = 0; i < NUM_SB; i++) begin
         n_dve = 0;
         for (int k = 1; k < CFG_W - 1; k += 2)
            n_dve += int'(s[i*CFG_W + k]);
         if (n_dve > 2)
            ok = 1'b0;
      end
      return ok;
   endfunction

   // A restart in the same cycle wins over a presented bit; that bit is dropped.
   assign accept    = (state == SHIFT) && cfg_valid && !cfg_start;
   assign cfg_ready = (state == SHIFT);
   assign busy      = (state != IDLE);

`ifdef SB_CFG_PARITY_EN
   assign frame_ok = all_words_legal(shadow) && ((^shadow ^ par_bit) == 1'b0);
`else
   assign frame_ok = all_words_legal(shadow);
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cfg_start) state_nxt = SHIFT;
         SHIFT:   if (accept && bit_cnt == LAST_BIT) state_nxt = CHECK;
         CHECK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shadow     <= '0;
         bit_cnt    <= '0;
         config_out <= '0;
         cfg_done   <= 1'b0;
         cfg_error  <= 1'b0;
`ifdef SB_CFG_PARITY_EN
         par_bit    <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         cfg_done <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_start) begin
                  bit_cnt   <= '0;
                  shadow    <= '0;
                  cfg_error <= 1'b0;
               end
            end
            SHIFT: begin
               if (cfg_start) begin
                  bit_cnt <= '0;
                  shadow  <= '0;
               end else if (accept) begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef SB_CFG_PARITY_EN
                  // Trailing bit is parity; keep it out of the data shadow.
                  if (bit_cnt == CNT_W'(N))
                     par_bit <= cfg_bit;
                  else
                     shadow <= {shadow[N-2:0], cfg_bit};
`else
                  shadow <= {shadow[N-2:0], cfg_bit};
`endif
               end
            end
            CHECK: begin
               if (frame_ok) begin
                  config_out <= shadow;
                  cfg_done   <= 1'b1;
               end else begin
                  cfg_error  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sb_config_loader.sv
module tb_sb_config_loader;

   localparam int NSB = 2;
   localparam int W   = 9;
   localparam int N   = NSB * W;
`ifdef SB_CFG_PARITY_EN
   localparam int FRAME = N + 1;
`else
   localparam int FRAME = N;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         cfg_start = 1'b0;
   logic         cfg_valid = 1'b0;
   logic         cfg_bit = 1'b0;
   logic         cfg_ready, busy, cfg_done, cfg_error;
   logic [N-1:0] config_out;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;
   int done_pulses = 0;

   sb_config_loader #(.NUM_SB(NSB), .CFG_W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_start  (cfg_start),
      .cfg_valid  (cfg_valid),
      .cfg_bit    (cfg_bit),
      .cfg_ready  (cfg_ready),
      .busy       (busy),
      .cfg_done   (cfg_done),
      .cfg_error  (cfg_error),
      .config_out (config_out)
   );

   always #5 clk = ~clk;

   task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bits of a frame are collected in a queue. Once the
   // frame is complete, it is judged on the following cycle.
   logic [N-1:0] m_cfg;
   bit           m_err, m_done;
   int           m_phase;
   logic         q[$];

   function automatic bit judge_ok(input logic [N-1:0] d);
      bit ok = 1;
      for (int sb = 0; sb < NSB; sb++) begin
         logic [W-1:0] w;
         w = d[sb*W +: W];
         if (int'(w[7]) + int'(w[5]) + int'(w[3]) + int'(w[1]) > 2) ok = 0;
      end
`ifdef SB_CFG_PARITY_EN
      if ((^d) != q[N]) ok = 0;
`endif
      return ok;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_cfg = '0; m_err = 0; m_done = 0; m_phase = 0; q.delete();
      end else begin
         m_done = 0;
         if (m_phase == 0) begin
            if (cfg_start) begin m_phase = 1; m_err = 0; q.delete(); end
         end else if (m_phase == 1) begin
            if (cfg_start) q.delete();
            else if (cfg_valid) begin
               q.push_back(cfg_bit);
               if (q.size() == FRAME) m_phase = 2;
            end
         end else begin
            logic [N-1:0] d;
            for (int i = 0; i < N; i++) d[N-1-i] = q[i];
            if (judge_ok(d)) begin m_cfg = d; m_done = 1; end
            else m_err = 1;
            m_phase = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         expect_eq("cfg_ready",  32'(cfg_ready),  32'(m_phase == 1));
         expect_eq("busy",       32'(busy),       32'(m_phase != 0));
         expect_eq("cfg_done",   32'(cfg_done),   32'(m_done));
         expect_eq("cfg_error",  32'(cfg_error),  32'(m_err));
         expect_eq("config_out", 32'(config_out), 32'(m_cfg));
         if (cfg_done === 1'b1) done_pulses++;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      cfg_start = 1; cfg_valid = 0; tick(); cfg_start = 0;
   endtask

   // Send the top nbits of f MSB-first; gap_len idle cycles after bits ga and gb.
   task automatic shift_bits(input logic [FRAME-1:0] f, input int nbits,
                             input int ga, input int gb, input int gap_len);
      logic [FRAME-1:0] v;
      v = f;
      for (int j = 1; j <= nbits; j++) begin
         cfg_valid = 1; cfg_bit = v[FRAME-j]; tick();
         if (j == ga || j == gb) begin
            cfg_valid = 0;
            repeat (gap_len) tick();
         end
      end
      cfg_valid = 0;
   endtask

   task automatic send_frame(input logic [FRAME-1:0] f, input int ga, input int gb, input int gap_len);
      pulse_start();
      shift_bits(f, FRAME, ga, gb, gap_len);
      repeat (3) tick();
   endtask

   function automatic logic [FRAME-1:0] mk(input logic [N-1:0] d);
      logic [FRAME-1:0] f;
`ifdef SB_CFG_PARITY_EN
      f = {d, ^d};
`else
      f = d;
`endif
      return f;
   endfunction

   initial begin
      logic [N-1:0] fa, fb;
      fa = {9'h0C0, 9'h121};
      fb = {9'h0C0, 9'h02A};

      rst = 1; tick(); tick();
      chk_en = 1;
      rst = 0;
      expect_eq("rst_cfg",   32'(config_out), 32'h0);
      expect_eq("rst_ready", 32'(cfg_ready),  32'h0);
      expect_eq("rst_busy",  32'(busy),       32'h0);
      expect_eq("rst_err",   32'(cfg_error),  32'h0);
      tick();

      done_pulses = 0;
      send_frame(mk(fa), 0, 0, 0);
      expect_eq("s2_cfg",   32'(config_out), 32'h18121);
      expect_eq("s2_pulses", 32'(done_pulses), 32'd1);
      expect_eq("s2_busy",  32'(busy), 32'h0);

      done_pulses = 0;
      send_frame(mk(fa), 4, 11, 3);
      expect_eq("s3_cfg",    32'(config_out), 32'h18121);
      expect_eq("s3_pulses", 32'(done_pulses), 32'd1);

      done_pulses = 0;
      send_frame(mk(fb), 0, 0, 0);
      expect_eq("s4_err",    32'(cfg_error), 32'h1);
      expect_eq("s4_cfg",    32'(config_out), 32'h18121);
      expect_eq("s4_pulses", 32'(done_pulses), 32'd0);
      pulse_start();
      expect_eq("s4_err_clr", 32'(cfg_error), 32'h0);

      // Restart mid-frame from the SHIFT started just above.
      shift_bits(mk(fb), 7, 0, 0, 0);
      done_pulses = 0;
      send_frame(mk(fa), 0, 0, 0);
      expect_eq("s5_cfg",    32'(config_out), 32'h18121);
      expect_eq("s5_pulses", 32'(done_pulses), 32'd1);

      pulse_start();
      shift_bits(mk(fa), 10, 0, 0, 0);
      rst = 1; tick(); rst = 0;
      expect_eq("s5_rst_cfg",  32'(config_out), 32'h0);
      expect_eq("s5_rst_busy", 32'(busy), 32'h0);
      tick();

`ifdef SB_CFG_PARITY_EN
      send_frame(mk(fa), 0, 0, 0);
      expect_eq("s6_par_ok", 32'(config_out), 32'h18121);
      send_frame(mk(18'h00003) ^ 19'h1, 0, 0, 0);
      expect_eq("s6_par_err", 32'(cfg_error), 32'h1);
      expect_eq("s6_par_cfg", 32'(config_out), 32'h18121);
`endif

      for (int c = 0; c < 4000; c++) begin
         rst       = ($urandom_range(0, 599) == 0);
         cfg_start = ($urandom_range(0, 39) == 0);
         cfg_valid = ($urandom_range(0, 3) != 0);
         cfg_bit   = 1'($urandom_range(0, 1));
         tick();
      end
      rst = 0; cfg_start = 0; cfg_valid = 0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
